// File: rtl/store_commit_queue.sv
// Store buffer holding speculative stores until commit, then draining committed stores to the D$ in order.
// Define STQ_HWM_EN to build the occupancy high-water-mark register; otherwise hwm_o reads 0.
module store_commit_queue #(
  parameter int DEPTH  = 8,
  parameter int PLEN   = 56,
  parameter int DATA_W = 64,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   st_valid_i,
  output logic                   st_ready_o,
  input  logic [PLEN-1:0]        st_paddr_i,
  input  logic [DATA_W-1:0]      st_data_i,
  input  logic [BE_W-1:0]        st_be_i,
  input  logic                   commit_i,
  output logic                   commit_ready_o,
  output logic                   dc_req_o,
  input  logic                   dc_gnt_i,
  output logic [PLEN-1:0]        dc_paddr_o,
  output logic [DATA_W-1:0]      dc_data_o,
  output logic [BE_W-1:0]        dc_be_o,
  input  logic [11:0]            page_offset_i,
  output logic                   page_offset_match_o,
  output logic                   no_st_pending_o,
  output logic [$clog2(DEPTH):0] hwm_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [PLEN-1:0]   paddr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [BE_W-1:0]   be_mem    [DEPTH];

  logic [PW-1:0] rd_ptr, cm_ptr, wr_ptr;
  logic [CW-1:0] spec_cnt, comm_cnt;
  logic [CW:0]   occupancy;
  logic          push, commit, pop;

  assign occupancy       = {1'b0, spec_cnt} + {1'b0, comm_cnt};
  assign st_ready_o      = occupancy < DEPTH_C;
  assign commit_ready_o  = spec_cnt != '0;
  assign dc_req_o        = comm_cnt != '0;
  assign no_st_pending_o = occupancy == '0;

  assign push   = st_valid_i & st_ready_o & ~flush_i;
  assign commit = commit_i & commit_ready_o;
  assign pop    = dc_req_o & dc_gnt_i;

  // Oldest committed entry is presented until granted.
  assign dc_paddr_o = paddr_mem[rd_ptr];
  assign dc_data_o  = data_mem[rd_ptr];
  assign dc_be_o    = be_mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      cm_ptr   <= '0;
      wr_ptr   <= '0;
      spec_cnt <= '0;
      comm_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (commit)
        cm_ptr <= cm_ptr + PW'(1);
      if (flush_i) begin
        wr_ptr   <= cm_ptr + PW'(commit);
        spec_cnt <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        spec_cnt <= spec_cnt + CW'(push) - CW'(commit);
      end
      comm_cnt <= comm_cnt + CW'(commit) - CW'(pop);
    end
  end

  // NOTE: entry storage has no reset; the pointers and counters alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      paddr_mem[wr_ptr] <= st_paddr_i;
      data_mem[wr_ptr]  <= st_data_i;
      be_mem[wr_ptr]    <= st_be_i;
    end
  end

  // An entry is valid when its distance from the read pointer is below the occupancy.
  always_comb begin
    // NOTE: output defaulted before the loop so no path leaves it unassigned (no latch).
    page_offset_match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] age;
      age = PW'(i) - rd_ptr;
      if (({2'b00, age} < occupancy) && (paddr_mem[i][11:3] == page_offset_i[11:3]))
        page_offset_match_o = 1'b1;
    end
  end

`ifdef STQ_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      hwm_q <= '0;
    else if (occupancy > {1'b0, hwm_q})
      hwm_q <= occupancy[CW-1:0];
  end

  assign hwm_o = hwm_q;
`else
  assign hwm_o = '0;
`endif

  commit_needs_spec: assert property (@(posedge clk_i) disable iff (rst_i)
    !(commit_i && spec_cnt == '0));

endmodule

// File: tb/tb_store_commit_queue.sv
// Self-checking bench for store_commit_queue: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_store_commit_queue;
  localparam int DEPTH  = 8;
  localparam int PLEN   = 56;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
`ifdef STQ_HWM_EN
  localparam int HWM5 = 5;
`else
  localparam int HWM5 = 0;
`endif

  localparam logic [PLEN-1:0] Z = '0;
  localparam logic [PLEN-1:0] A = 56'h0000_0000_8000_0010;
  localparam logic [PLEN-1:0] B = 56'h0000_0000_8000_0028;
  localparam logic [PLEN-1:0] C = 56'h0000_0000_8000_0100;

  typedef struct {
    logic [PLEN-1:0]   paddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } ent_t;

  typedef struct {
    logic            v;
    logic [PLEN-1:0] pa;
    logic            c;
    logic            g;
    logic            f;
    logic [11:0]     po;
    logic            e_ready;
    logic            e_cready;
    logic            e_req;
    logic [PLEN-1:0] e_pa;
    logic            e_match;
    logic            e_nopend;
  } vec_t;

  logic              clk, rst, flush, st_valid, st_ready, commit, commit_ready;
  logic              dc_req, dc_gnt, page_offset_match, no_st_pending;
  logic [PLEN-1:0]   st_paddr, dc_paddr;
  logic [DATA_W-1:0] st_data, dc_data;
  logic [BE_W-1:0]   st_be, dc_be;
  logic [11:0]       page_offset;
  logic [3:0]        hwm;

  int   total = 0;
  int   bad   = 0;
  ent_t spec_q[$];
  ent_t comm_q[$];
  vec_t vecs[12];

  store_commit_queue #(.DEPTH(DEPTH), .PLEN(PLEN), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_paddr_i(st_paddr), .st_data_i(st_data), .st_be_i(st_be),
    .commit_i(commit), .commit_ready_o(commit_ready),
    .dc_req_o(dc_req), .dc_gnt_i(dc_gnt),
    .dc_paddr_o(dc_paddr), .dc_data_o(dc_data), .dc_be_o(dc_be),
    .page_offset_i(page_offset), .page_offset_match_o(page_offset_match),
    .no_st_pending_o(no_st_pending), .hwm_o(hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [PLEN-1:0] addr(input logic [PLEN-1:0] base, input int k, input int step);
    return base + PLEN'(k * step);
  endfunction

  task automatic drive(input logic v, input logic [PLEN-1:0] pa, input logic c,
                       input logic g, input logic f, input logic [11:0] po);
    st_valid    = v;
    st_paddr    = pa;
    st_data     = {pa[23:0], pa[55:16]};
    st_be       = pa[10:3] ^ 8'h5a;
    commit      = c;
    dc_gnt      = g;
    flush       = f;
    page_offset = po;
  endtask

  // Reference model: speculative and committed stores as two FIFOs of whole entries.
  task automatic model_check();
    logic em;
    em = 1'b0;
    foreach (spec_q[i]) if (spec_q[i].paddr[11:3] == page_offset[11:3]) em = 1'b1;
    foreach (comm_q[i]) if (comm_q[i].paddr[11:3] == page_offset[11:3]) em = 1'b1;
    check("m_ready",  64'(st_ready),          64'((spec_q.size() + comm_q.size()) < DEPTH));
    check("m_cready", 64'(commit_ready),      64'(spec_q.size() > 0));
    check("m_req",    64'(dc_req),            64'(comm_q.size() > 0));
    check("m_nopend", 64'(no_st_pending),     64'((spec_q.size() + comm_q.size()) == 0));
    check("m_match",  64'(page_offset_match), 64'(em));
    if (comm_q.size() > 0) begin
      check("m_paddr", 64'(dc_paddr), 64'(comm_q[0].paddr));
      check("m_data",  dc_data,       comm_q[0].data);
      check("m_be",    64'(dc_be),    64'(comm_q[0].be));
    end
  endtask

  task automatic model_update();
    ent_t e;
    bit   do_pop, do_commit, do_push;
    do_pop    = dc_gnt && comm_q.size() > 0;
    do_commit = commit && spec_q.size() > 0;
    do_push   = st_valid && !flush && (spec_q.size() + comm_q.size()) < DEPTH;
    if (do_pop) void'(comm_q.pop_front());
    if (do_commit) comm_q.push_back(spec_q.pop_front());
    if (flush) spec_q.delete();
    if (do_push) begin
      e.paddr = st_paddr;
      e.data  = st_data;
      e.be    = st_be;
      spec_q.push_back(e);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
    drive(1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic cycle(input logic v, input logic [PLEN-1:0] pa, input logic c,
                       input logic g, input logic f, input logic [11:0] po);
    drive(v, pa, c, g, f, po);
    #1;
    model_check();
    advance();
  endtask

  task automatic do_reset();
    drive(1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h0);
    rst = 1'b1;
    #3;
    spec_q.delete();
    comm_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * DEPTH && (spec_q.size() + comm_q.size()) > 0; n++)
      cycle(1'b0, Z, spec_q.size() > 0, 1'b1, 1'b0, 12'h0);
    check("drain_done", 64'(no_st_pending), 64'(1));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h0);
    #2;
    check("rst_ready",  64'(st_ready),          64'(1));
    check("rst_cready", 64'(commit_ready),      64'(0));
    check("rst_req",    64'(dc_req),            64'(0));
    check("rst_nopend", 64'(no_st_pending),     64'(1));
    check("rst_match",  64'(page_offset_match), 64'(0));
    check("rst_hwm",    64'(hwm),               64'(0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Push A,B,C; probe offsets; commit A and hold grant low for 4 cycles, then grant.
    //          v     pa  c     g     f     po       ready cready req   e_pa match nopend
    vecs[0]  = '{1'b1, A, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, Z, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, B, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 1'b1, 1'b0, Z, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, C, 1'b0, 1'b0, 1'b0, 12'h028, 1'b1, 1'b1, 1'b0, Z, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h028, 1'b1, 1'b1, 1'b0, Z, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h030, 1'b1, 1'b1, 1'b0, Z, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h030, 1'b1, 1'b1, 1'b0, Z, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 1'b1, 1'b1, A, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, A, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, A, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, A, 1'b0, 1'b0};
    vecs[10] = '{1'b0, Z, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, A, 1'b0, 1'b0};
    vecs[11] = '{1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 1'b1, 1'b0, Z, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      vec_t t;
      t = vecs[i];
      drive(t.v, t.pa, t.c, t.g, t.f, t.po);
      #1;
      model_check();
      check("t_ready",  64'(st_ready),          64'(t.e_ready));
      check("t_cready", 64'(commit_ready),      64'(t.e_cready));
      check("t_req",    64'(dc_req),            64'(t.e_req));
      check("t_match",  64'(page_offset_match), 64'(t.e_match));
      check("t_nopend", 64'(no_st_pending),     64'(t.e_nopend));
      if (t.e_req) check("t_paddr", 64'(dc_paddr), 64'(t.e_pa));
      advance();
    end

    // Fill to DEPTH; extra pushes (alone and alongside a pop) are refused.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, addr(56'hB000_0000, i, 8), 1'b0, 1'b0, 1'b0, 12'h0);
    check("full_ready", 64'(st_ready), 64'(0));
    cycle(1'b1, 56'hBAD0_0000, 1'b0, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    drive(1'b1, 56'hBAD1_0000, 1'b0, 1'b1, 1'b0, 12'h0);
    #1;
    model_check();
    check("full_pop_ready", 64'(st_ready), 64'(0));
    advance();
    check("ready_after_pop", 64'(st_ready), 64'(1));
    drain();

    // Flush with simultaneous push and commit: exactly three committed stores survive.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, addr(56'h9000_0000, i, 64), 1'b0, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    cycle(1'b1, addr(56'h9000_0000, 4, 64), 1'b1, 1'b0, 1'b1, 12'h0);
    check("flush_cready", 64'(commit_ready), 64'(0));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, Z, 1'b0, 1'b1, 1'b0, 12'h0);
      #1;
      model_check();
      check("flush_drain_pa", 64'(dc_paddr), 64'(addr(56'h9000_0000, k, 64)));
      advance();
    end
    check("flush_nopend", 64'(no_st_pending), 64'(1));
    check("flush_req",    64'(dc_req),        64'(0));

    // Asynchronous reset while two committed stores wait for grant.
    do_reset();
    cycle(1'b1, 56'h7000_0000, 1'b0, 1'b0, 1'b0, 12'h0);
    cycle(1'b1, 56'h7000_0008, 1'b0, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    check("pre_rst_req", 64'(dc_req), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_req",    64'(dc_req),        64'(0));
    check("async_rst_nopend", 64'(no_st_pending), 64'(1));
    check("async_rst_hwm",    64'(hwm),           64'(0));
    spec_q.delete();
    comm_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cycle(1'b1, addr(56'h7100_0000, i, 8), 1'b0, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h0);
    check("hwm_five", 64'(hwm), 64'(HWM5));
    drain();
    cycle(1'b0, Z, 1'b0, 1'b0, 1'b0, 12'h0);
    check("hwm_hold", 64'(hwm), 64'(HWM5));

    // Steady state: push, commit and pop every cycle for 20 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, addr(56'hA000_0000, i, 8), 1'b0, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    cycle(1'b0, Z, 1'b1, 1'b0, 1'b0, 12'h0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, addr(56'hA000_0000, k + 4, 8), 1'b1, 1'b1, 1'b0, 12'h0);
      #1;
      model_check();
      check("ss_paddr", 64'(dc_paddr), 64'(addr(56'hA000_0000, k, 8)));
      check("ss_ready", 64'(st_ready), 64'(1));
      advance();
    end
    drain();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [PLEN-1:0] pa;
      logic [11:0]     po;
      logic            v, c, g, f;
      pa = PLEN'({$urandom(), $urandom()});
      po = 12'($urandom());
      if (comm_q.size() > 0 && $urandom_range(3, 0) == 0) po = comm_q[0].paddr[11:0];
      else if (spec_q.size() > 0 && $urandom_range(2, 0) == 0) po = spec_q[$].paddr[11:0];
      v = $urandom_range(99, 0) < 60;
      c = (spec_q.size() > 0) && ($urandom_range(99, 0) < 45);
      g = $urandom_range(99, 0) < 45;
      f = $urandom_range(99, 0) < 4;
      cycle(v, pa, c, g, f, po);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
